// File: rtl/companion_care_scheduler.sv
// Round-robin care-action scheduler: latches feed/play/clean requests, issues one action pulse, then enforces a cooldown.
// Optional build macro COMPANION_AUTO_CARE_EN lets the status inputs raise requests while nothing is pending.
module companion_care_scheduler #(
  parameter int unsigned CLOCK_FREQ    = 50_000_000,
  parameter int unsigned COOLDOWN_SEC  = 2,
  parameter logic [31:0] HUNGER_THRESH = 32'd80,
  parameter logic [31:0] HAPPY_THRESH  = 32'd20,
  parameter logic [31:0] CLEAN_THRESH  = 32'd20
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_feed,
  input  logic        req_play,
  input  logic        req_clean,
  input  logic [31:0] hunger,
  input  logic [31:0] happiness,
  input  logic [31:0] clean,
  output logic        feed,
  output logic        play,
  output logic        clean_up,
  output logic        busy,
  output logic [2:0]  pending,
  output logic        dropped
);

  localparam logic [31:0] COOLDOWN_CYCLES = 32'(COOLDOWN_SEC * CLOCK_FREQ);

  typedef enum logic [1:0] {IDLE, ISSUE, COOLDOWN} state_t;

  state_t      state_q;
  logic [31:0] cnt_q;
  logic [1:0]  rr_q, rr_d;
  logic [2:0]  pending_q, pending_d;
  logic [2:0]  act_q;
  logic        busy_q;
  logic        dropped_q, dropped_d;

  logic [2:0]  req_vec, auto_vec, auto_set, cand, gnt_oh, clr;
  logic [1:0]  gnt_idx, sel;
  logic        ready, do_grant;

  function automatic logic [1:0] wrap3(input logic [2:0] v);
    return 2'(v >= 3'd3 ? v - 3'd3 : v);
  endfunction

`ifndef COMPANION_AUTO_CARE_EN
  logic unused_status;
  assign unused_status = ^{hunger, happiness, clean, HUNGER_THRESH, HAPPY_THRESH, CLEAN_THRESH};
`endif

  always_comb begin
    req_vec  = {req_clean, req_play, req_feed};
    auto_vec = 3'b000;
`ifdef COMPANION_AUTO_CARE_EN
    auto_vec = {clean < CLEAN_THRESH, happiness < HAPPY_THRESH, hunger >= HUNGER_THRESH};
`endif
    // The last cooldown edge can grant directly, giving one action per COOLDOWN_CYCLES+1 cycles.
    ready    = (state_q == IDLE) || (state_q == COOLDOWN && cnt_q == 32'd0);
    auto_set = (ready && pending_q == 3'b000) ? auto_vec : 3'b000;
    cand     = pending_q | auto_set;
    gnt_oh   = 3'b000;
    gnt_idx  = 2'd0;
    sel      = 2'd0;
    // Walk from the farthest candidate back to rr so the nearest one wins.
    for (int k = 2; k >= 0; k--) begin
      sel = wrap3(3'(rr_q) + 3'(k));
      if (cand[sel]) begin
        gnt_oh      = 3'b000;
        gnt_oh[sel] = 1'b1;
        gnt_idx     = sel;
      end
    end
    do_grant  = ready && (cand != 3'b000);
    clr       = do_grant ? gnt_oh : 3'b000;
    // A request on the bit being granted re-sets it and is not counted as dropped.
    pending_d = ((pending_q | auto_set) & ~clr) | req_vec;
    dropped_d = |(req_vec & pending_q & ~clr);
    rr_d      = (gnt_idx == 2'd2) ? 2'd0 : gnt_idx + 2'd1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      cnt_q     <= 32'd0;
      rr_q      <= 2'd0;
      pending_q <= 3'b000;
      act_q     <= 3'b000;
      busy_q    <= 1'b0;
      dropped_q <= 1'b0;
    end else begin
      pending_q <= pending_d;
      dropped_q <= dropped_d;
      act_q     <= 3'b000;
      case (state_q)
        IDLE: begin
          if (do_grant) begin
            state_q <= ISSUE;
            act_q   <= gnt_oh;
            rr_q    <= rr_d;
            busy_q  <= 1'b1;
          end
        end
        ISSUE: begin
          if (COOLDOWN_CYCLES == 32'd0) begin
            state_q <= IDLE;
            busy_q  <= 1'b0;
          end else begin
            state_q <= COOLDOWN;
            cnt_q   <= COOLDOWN_CYCLES - 32'd1;
          end
        end
        COOLDOWN: begin
          if (cnt_q != 32'd0) begin
            cnt_q <= cnt_q - 32'd1;
          end else if (do_grant) begin
            state_q <= ISSUE;
            act_q   <= gnt_oh;
            rr_q    <= rr_d;
          end else begin
            state_q <= IDLE;
            busy_q  <= 1'b0;
          end
        end
        default: begin
          state_q <= IDLE;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign feed     = act_q[0];
  assign play     = act_q[1];
  assign clean_up = act_q[2];
  assign busy     = busy_q;
  assign pending  = pending_q;
  assign dropped  = dropped_q;

endmodule
